// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency doubleword data-memory responder with valid/ready request and response.
module dmem_responder #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [63:0]    addr_q, addr_d;
   logic [63:0]    wdata_q, wdata_d;
   logic [63:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic           mem_we;
   logic           access_err;
   logic [AW-1:0]  idx;

   logic [63:0] mem [DEPTH];

   // Full 64-bit compare so high addresses never alias onto a valid index.
   assign access_err = (addr_q[2:0] != 3'd0) || (addr_q >= LIMIT);
   assign idx        = addr_q[3 +: AW];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CW'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               err_d   = access_err;
               rdata_d = 64'd0;
               if (!access_err) begin
                  if (we_q) begin
                     mem_we = 1'b1;
                  end else begin
                     rdata_d = mem[idx];
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[idx] <= wdata_q;
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and model-checked bench for dmem_responder.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;

   logic        sv_valid [2];
   logic        sv_ready [2];
   logic        sv_we    [2];
   logic [63:0] sv_addr  [2];
   logic [63:0] sv_wdata [2];
   logic        sv_rvalid[2];
   logic        sv_rready[2];
   logic [63:0] sv_rdata [2];
   logic        sv_err   [2];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(512), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH(16), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .req_valid(sv_valid[0]), .req_ready(sv_ready[0]), .req_we(sv_we[0]),
      .req_addr(sv_addr[0]), .req_wdata(sv_wdata[0]),
      .rsp_valid(sv_rvalid[0]), .rsp_ready(sv_rready[0]),
      .rsp_rdata(sv_rdata[0]), .rsp_err(sv_err[0])
   );

   dmem_responder #(.DEPTH(16), .LATENCY(4)) u_lat4 (
      .clk(clk), .rst(rst),
      .req_valid(sv_valid[1]), .req_ready(sv_ready[1]), .req_we(sv_we[1]),
      .req_addr(sv_addr[1]), .req_wdata(sv_wdata[1]),
      .rsp_valid(sv_rvalid[1]), .rsp_ready(sv_rready[1]),
      .rsp_rdata(sv_rdata[1]), .rsp_err(sv_err[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input int stall, output logic [63:0] rdata, output logic err,
                         output int lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = (stall == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      if (!rsp_valid) begin
         check("rsp_timeout", 64'(rsp_valid), 64'd1);
         rsp_ready = 1'b1;
         return;
      end
      repeat (stall) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic sweep(input int k, input int exp_lat, input int exp_period);
      int   acc[$];
      int   first_rsp;
      logic rdy;
      first_rsp = -1;
      @(negedge clk);
      sv_valid[k] = 1'b1;
      sv_we[k]    = 1'b1;
      sv_addr[k]  = 64'h8;
      sv_wdata[k] = 64'h55;
      for (int c = 1; c <= 20; c++) begin
         rdy = sv_ready[k];
         @(posedge clk);
         if (rdy) acc.push_back(c);
         #1;
         if (sv_rvalid[k] && first_rsp < 0) first_rsp = c;
         @(negedge clk);
      end
      sv_valid[k] = 1'b0;
      repeat (10) @(posedge clk);
      if (acc.size() < 2 || first_rsp < 0) begin
         check($sformatf("sweep%0d_activity", k), 64'd0, 64'd1);
      end else begin
         check($sformatf("sweep%0d_latency", k), 64'(first_rsp - acc[0]), 64'(exp_lat));
         check($sformatf("sweep%0d_period", k), 64'(acc[1] - acc[0]), 64'(exp_period));
      end
   endtask

   logic [63:0] rd, exp_rd;
   logic        er, exp_er;
   int          lat, wcnt;
   logic [63:0] model [int];

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sv_valid[k] = 1'b0; sv_we[k] = 1'b0; sv_addr[k] = '0; sv_wdata[k] = '0;
         sv_rready[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_rdata", rsp_rdata, 64'd0);
      check("reset_rsp_err", 64'(rsp_err), 64'd0);

      do_req(1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567, 0, rd, er, lat);
      check("st40_latency", 64'(lat), 64'd2);
      check("st40_rdata", rd, 64'd0);
      check("st40_err", 64'(er), 64'd0);
      do_req(1'b0, 64'h40, 64'd0, 0, rd, er, lat);
      check("ld40_rdata", rd, 64'hDEAD_BEEF_0123_4567);
      check("ld40_err", 64'(er), 64'd0);

      do_req(1'b1, 64'h41, 64'h0BAD, 0, rd, er, lat);
      check("st41_err", 64'(er), 64'd1);
      check("st41_rdata", rd, 64'd0);
      do_req(1'b0, 64'h40, 64'd0, 0, rd, er, lat);
      check("ld40_after_bad", rd, 64'hDEAD_BEEF_0123_4567);
      do_req(1'b0, 64'h1000, 64'd0, 0, rd, er, lat);
      check("ld1000_err", 64'(er), 64'd1);
      check("ld1000_rdata", rd, 64'd0);
      do_req(1'b1, 64'hFF8, 64'hA5A5_5A5A_0F0F_F0F0, 0, rd, er, lat);
      check("stff8_err", 64'(er), 64'd0);
      do_req(1'b0, 64'hFF8, 64'd0, 0, rd, er, lat);
      check("ldff8_err", 64'(er), 64'd0);
      check("ldff8_rdata", rd, 64'hA5A5_5A5A_0F0F_F0F0);
      do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7777, 0, rd, er, lat);
      check("st_top_err", 64'(er), 64'd1);
      do_req(1'b0, 64'h0, 64'd0, 1, rd, er, lat);
      do_req(1'b0, 64'h1F8, 64'd0, 0, rd, er, lat);
      check("ld1f8_err", 64'(er), 64'd0);
      do_req(1'b0, 64'h40, 64'd0, 2, rd, er, lat);
      check("ld40_no_alias", rd, 64'hDEAD_BEEF_0123_4567);

      // Backpressure with a second request pending behind the response.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h40;
      @(posedge clk);
      #1;
      req_addr = 64'hFF8;
      wcnt = 0;
      while (!rsp_valid && wcnt < 20) begin
         @(posedge clk);
         #1;
         wcnt++;
      end
      check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_valid_%0d", i), 64'(rsp_valid), 64'd1);
         check($sformatf("bp_rdata_%0d", i), rsp_rdata, 64'hDEAD_BEEF_0123_4567);
         check($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_hs_ready", 64'(req_ready), 64'd1);
      check("bp_after_hs_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      check("bp_second_accepted", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      wcnt = 0;
      while (!rsp_valid && wcnt < 20) begin
         @(posedge clk);
         #1;
         wcnt++;
      end
      check("bp_second_rdata", rsp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
      @(posedge clk);
      #1;

      // Reset landing on the commit edge of a store.
      do_req(1'b1, 64'h80, 64'h2222, 0, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h80; req_wdata = 64'h1111;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_wait_req_ready", 64'(req_ready), 64'd1);
      check("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_wait_rdata", rsp_rdata, 64'd0);
      do_req(1'b0, 64'h80, 64'd0, 0, rd, er, lat);
      check("rst_wait_ld80", rd, 64'h2222);

      // Reset while the store response is stalled.
      do_req(1'b0, 64'h40, 64'd0, 0, rd, er, lat);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h80; req_wdata = 64'h1111;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_in_resp", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      check("rst_resp_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp_rsp_valid", 64'(rsp_valid), 64'd0);
      do_req(1'b0, 64'h80, 64'd0, 0, rd, er, lat);
      check("rst_resp_ld80", rd, 64'h1111);

      sweep(0, 1, 3);
      sweep(1, 4, 6);

      model[8]   = 64'hDEAD_BEEF_0123_4567;
      model[16]  = 64'h1111;
      model[511] = 64'hA5A5_5A5A_0F0F_F0F0;
      for (int i = 0; i < 300; i++) begin
         int          r, key, stall;
         logic        we;
         logic [63:0] addr, wdata;
         r     = $urandom_range(0, 9);
         addr  = 64'($urandom_range(0, 31)) << 3;
         if (r == 0) addr = addr | 64'($urandom_range(1, 7));
         if (r == 1) addr = 64'h1000 + (64'($urandom_range(0, 64)) << 3);
         if (r == 2) addr = 64'hFFFF_FFFF_FFFF_FFF8;
         we    = 1'($urandom_range(0, 1));
         wdata = {$urandom, $urandom};
         stall = $urandom_range(0, 3);
         do_req(we, addr, wdata, stall, rd, er, lat);
         exp_er = (addr[2:0] != 3'd0) || (addr >= 64'h1000);
         key    = int'(addr[15:3]);
         check($sformatf("rnd%0d_err", i), 64'(er), 64'(exp_er));
         if (exp_er || we) begin
            check($sformatf("rnd%0d_rdata", i), rd, 64'd0);
         end else if (model.exists(key)) begin
            exp_rd = model[key];
            check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
         end
         if (we && !exp_er) model[key] = wdata;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
